// File: rtl/adc_mon_pkg.sv
// Shared types for the ADC fault monitor: FSM state encoding and fault codes.
package adc_mon_pkg;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        MONITOR = 2'd1,
        FAULT   = 2'd2
    } mon_state_e;

    localparam logic [1:0] FC_NONE  = 2'b00;
    localparam logic [1:0] FC_OVER  = 2'b01;
    localparam logic [1:0] FC_UNDER = 2'b10;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through capture FIFO with sticky overflow.
// Pointers carry one extra MSB so full and empty are distinguishable.
module sync_fifo #(
    parameter int DATA_W  = 12,
    parameter int FIFO_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              overflow_o
);

    localparam int DEPTH = 1 << FIFO_AW;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [FIFO_AW:0]  wptr_q, wptr_d;
    logic [FIFO_AW:0]  rptr_q, rptr_d;
    logic              overflow_q, overflow_d;
    logic              do_rd, do_wr;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                     (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);

    // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
    assign do_rd = rd_en_i && !empty_o;
    assign do_wr = wr_en_i && (!full_o || do_rd);

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        overflow_d = overflow_q;
        if (do_wr) wptr_d = wptr_q + 1'b1;
        if (do_rd) rptr_d = rptr_q + 1'b1;
        if (wr_en_i && !do_wr) overflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wptr_q[FIFO_AW-1:0]] <= wr_data_i;
    end

    assign rd_data_o  = empty_o ? '0 : mem_q[rptr_q[FIFO_AW-1:0]];
    assign overflow_o = overflow_q;

endmodule

// File: rtl/adc_fault_monitor.sv
// ADC sample monitor: moving average, latched over/under-range fault, raw capture FIFO.
// Define FAULT_FREEZE_EN to block FIFO writes while a fault is latched.
//
// state   | meaning
// FILL    | ring not yet full, avg_valid suppressed
// MONITOR | classify each average against thresholds
// FAULT   | fault latched, counters frozen until clear_fault
module adc_fault_monitor
    import adc_mon_pkg::*;
#(
    parameter int DATA_W    = 12,
    parameter int AVG_LOG2  = 3,
    parameter int FAULT_CNT = 4,
    parameter int FIFO_AW   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] thresh_hi,
    input  logic [DATA_W-1:0] thresh_lo,
    input  logic              clear_fault,
    output logic [DATA_W-1:0] avg_out,
    output logic              avg_valid,
    output logic              fault,
    output logic [1:0]        fault_code,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic              overflow
);

    localparam int          DEPTH    = 1 << AVG_LOG2;
    localparam int          SUM_W    = DATA_W + AVG_LOG2;
    localparam logic [7:0]  TRIP_CNT = FAULT_CNT[7:0];
    localparam logic [AVG_LOG2-1:0] LAST_SLOT = AVG_LOG2'(DEPTH - 1);

    mon_state_e          state_q, state_d;
    logic [DATA_W-1:0]   ring_q [DEPTH];
    logic [AVG_LOG2-1:0] wptr_q;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [DATA_W-1:0]   avg_q;
    logic                avg_valid_q, avg_valid_d;
    logic [7:0]          over_q, over_d;
    logic [7:0]          under_q, under_d;
    logic [1:0]          code_q, code_d;
    logic                fifo_wr;

    assign sum_d = sum_q + SUM_W'(sample_in) - SUM_W'(ring_q[wptr_q]);

    // During FILL the write pointer doubles as the fill count.
    assign avg_valid_d = sample_valid && ((state_q != FILL) || (wptr_q == LAST_SLOT));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
            wptr_q      <= '0;
            sum_q       <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
        end else begin
            avg_valid_q <= avg_valid_d;
            if (sample_valid) begin
                ring_q[wptr_q] <= sample_in;
                wptr_q         <= wptr_q + 1'b1;
                sum_q          <= sum_d;
                avg_q          <= sum_d[SUM_W-1:AVG_LOG2];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        over_d  = over_q;
        under_d = under_q;
        code_d  = code_q;
        case (state_q)
            FILL: begin
                if (sample_valid && (wptr_q == LAST_SLOT)) state_d = MONITOR;
            end
            MONITOR: begin
                if (avg_valid_q) begin
                    // Over is tested first so a misconfigured lo > hi reports over.
                    if (avg_q > thresh_hi) begin
                        over_d  = over_q + 1'b1;
                        under_d = '0;
                    end else if (avg_q < thresh_lo) begin
                        under_d = under_q + 1'b1;
                        over_d  = '0;
                    end else begin
                        over_d  = '0;
                        under_d = '0;
                    end
                    if ((over_d == TRIP_CNT) || (under_d == TRIP_CNT)) begin
                        if (clear_fault) begin
                            over_d  = '0;
                            under_d = '0;
                        end else begin
                            state_d = FAULT;
                            code_d  = (over_d == TRIP_CNT) ? FC_OVER : FC_UNDER;
                        end
                    end
                end
            end
            FAULT: begin
                if (clear_fault) begin
                    state_d = MONITOR;
                    over_d  = '0;
                    under_d = '0;
                    code_d  = FC_NONE;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            over_q  <= '0;
            under_q <= '0;
            code_q  <= FC_NONE;
        end else begin
            state_q <= state_d;
            over_q  <= over_d;
            under_q <= under_d;
            code_q  <= code_d;
        end
    end

    assign avg_out    = avg_q;
    assign avg_valid  = avg_valid_q;
    assign fault      = (state_q == FAULT);
    assign fault_code = code_q;

`ifdef FAULT_FREEZE_EN
    assign fifo_wr = sample_valid && !fault;
`else
    assign fifo_wr = sample_valid;
`endif

    sync_fifo #(
        .DATA_W  (DATA_W),
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (fifo_wr),
        .wr_data_i  (sample_in),
        .rd_en_i    (rd_en),
        .rd_data_o  (rd_data),
        .empty_o    (empty),
        .full_o     (full),
        .overflow_o (overflow)
    );

endmodule

// File: tb/tb_adc_fault_monitor.sv
// Self-checking bench for adc_fault_monitor against a transaction-level reference model.
module tb_adc_fault_monitor;

    localparam int DATA_W    = 12;
    localparam int WIN       = 8;
    localparam int FAULT_CNT = 4;
    localparam int FIFO_DEPTH = 16;
`ifdef FAULT_FREEZE_EN
    localparam bit FREEZE = 1'b1;
`else
    localparam bit FREEZE = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [DATA_W-1:0] sample_in = '0;
    logic              sample_valid = 1'b0;
    logic [DATA_W-1:0] thresh_hi = 12'hFFF;
    logic [DATA_W-1:0] thresh_lo = 12'h000;
    logic              clear_fault = 1'b0;
    logic [DATA_W-1:0] avg_out;
    logic              avg_valid;
    logic              fault;
    logic [1:0]        fault_code;
    logic              rd_en = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              empty, full, overflow;

    always #10 clk = ~clk;

    adc_fault_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .thresh_hi    (thresh_hi),
        .thresh_lo    (thresh_lo),
        .clear_fault  (clear_fault),
        .avg_out      (avg_out),
        .avg_valid    (avg_valid),
        .fault        (fault),
        .fault_code   (fault_code),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .empty        (empty),
        .full         (full),
        .overflow     (overflow)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int   win[$];
    int   n_samples;
    int   m_avg;
    bit   m_avg_valid;
    int   m_over, m_under;
    bit   m_fault;
    int   m_code;
    int   m_fifo[$];
    bit   m_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        win.delete();
        m_fifo.delete();
        n_samples   = 0;
        m_avg       = 0;
        m_avg_valid = 0;
        m_over      = 0;
        m_under     = 0;
        m_fault     = 0;
        m_code      = 0;
        m_ovf       = 0;
    endtask

    // Would the average currently awaiting classification complete a run of FAULT_CNT?
    function automatic bit trip_next();
        if (m_fault || !m_avg_valid) return 1'b0;
        if (m_avg > int'(thresh_hi)) return (m_over + 1 == FAULT_CNT);
        if (m_avg < int'(thresh_lo)) return (m_under + 1 == FAULT_CNT);
        return 1'b0;
    endfunction

    task automatic step(input bit v, input int d, input bit clr, input bit rd, input bit r = 1'b0);
        bit pend_valid, fault_before, do_rd, do_wr;
        int pend_avg, s;
        sample_in    = d[DATA_W-1:0];
        sample_valid = v;
        clear_fault  = clr;
        rd_en        = rd;
        rst          = r;
        @(posedge clk);
        #1;
        if (r) begin
            model_reset();
        end else begin
            pend_valid   = m_avg_valid;
            pend_avg     = m_avg;
            fault_before = m_fault;
            if (m_fault) begin
                if (clr) begin
                    m_fault = 0; m_over = 0; m_under = 0; m_code = 0;
                end
            end else if (pend_valid) begin
                if (pend_avg > int'(thresh_hi)) begin
                    m_over++; m_under = 0;
                end else if (pend_avg < int'(thresh_lo)) begin
                    m_under++; m_over = 0;
                end else begin
                    m_over = 0; m_under = 0;
                end
                if (m_over == FAULT_CNT || m_under == FAULT_CNT) begin
                    if (clr) begin
                        m_over = 0; m_under = 0;
                    end else begin
                        m_fault = 1;
                        m_code  = (m_over == FAULT_CNT) ? 1 : 2;
                    end
                end
            end
            m_avg_valid = 0;
            if (v) begin
                win.push_back(d);
                if (win.size() > WIN) void'(win.pop_front());
                n_samples++;
                s = 0;
                foreach (win[i]) s += win[i];
                m_avg       = s / WIN;
                m_avg_valid = (n_samples >= WIN);
            end
            do_rd = rd && (m_fifo.size() > 0);
            do_wr = v && !(FREEZE && fault_before);
            if (do_wr && m_fifo.size() == FIFO_DEPTH && !do_rd) begin
                m_ovf = 1;
            end else begin
                if (do_rd) void'(m_fifo.pop_front());
                if (do_wr) m_fifo.push_back(d);
            end
        end
        check("avg_valid",  avg_valid,  m_avg_valid);
        check("avg_out",    avg_out,    m_avg);
        check("fault",      fault,      m_fault);
        check("fault_code", fault_code, m_code);
        check("empty",      empty,      m_fifo.size() == 0);
        check("full",       full,       m_fifo.size() == FIFO_DEPTH);
        check("overflow",   overflow,   m_ovf);
        check("rd_data",    rd_data,    (m_fifo.size() > 0) ? m_fifo[0] : 0);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
    endtask

    task automatic fill(input int d);
        for (int i = 0; i < WIN; i++) step(1, d, 0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < FIFO_DEPTH + 2; i++) step(0, 0, 0, 1);
    endtask

    int first_word;
    int mode;

    initial begin
        model_reset();
        do_reset();
        check("rst_empty", empty, 1);
        check("rst_fault", fault, 0);

        // 1: fill with mid-scale
        thresh_hi = 12'hFFF; thresh_lo = 12'h000;
        for (int i = 0; i < WIN - 1; i++) step(1, 'h800, 0, 0);
        check("t1_no_valid_early", avg_valid, 0);
        step(1, 'h800, 0, 0);
        check("t1_valid_8th", avg_valid, 1);
        check("t1_avg", avg_out, 12'h800);
        step(0, 0, 0, 0);
        check("t1_fault", fault, 0);

        // 2: over-range trip
        do_reset();
        thresh_hi = 12'hC00; thresh_lo = 12'h080;
        fill('h100);
        for (int i = 0; i < 16; i++) step(1, 'hFFF, 0, 0);
        step(0, 0, 0, 0);
        check("t2_fault", fault, 1);
        check("t2_code", fault_code, 2'b01);

        // 3: alternating then sustained low
        do_reset();
        thresh_hi = 12'hC00; thresh_lo = 12'h7F0;
        fill('h800);
        for (int i = 0; i < 6; i++) begin
            step(1, 'h700, 0, 0); step(0, 0, 0, 0);
            step(1, 'h900, 0, 0); step(0, 0, 0, 0);
        end
        check("t3_no_fault", fault, 0);
        for (int i = 0; i < 12; i++) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        check("t3_code", fault_code, 2'b10);

        // 4: clear coincident with trip discards it and zeroes counters
        do_reset();
        thresh_hi = 12'hC00; thresh_lo = 12'h000;
        fill('h800);
        for (int i = 0; i < 12; i++) begin
            bit hit;
            step(1, 'hFFF, 0, 0);
            hit = trip_next();
            step(0, 0, hit, 0);
            if (hit) break;
        end
        check("t4_cleared", fault, 0);
        for (int i = 0; i < FAULT_CNT - 1; i++) begin
            step(1, 'hFFF, 0, 0); step(0, 0, 0, 0);
        end
        check("t4_restart", fault, 0);
        step(1, 'hFFF, 0, 0); step(0, 0, 0, 0);
        check("t4_retrip", fault, 1);

        // 5: FIFO full / overflow / drain / simultaneous rd-wr
        do_reset();
        thresh_hi = 12'hFFF; thresh_lo = 12'h000;
        first_word = $urandom_range(0, 4095);
        step(1, first_word, 0, 0);
        for (int i = 0; i < FIFO_DEPTH; i++) step(1, $urandom_range(0, 4095), 0, 0);
        check("t5_full", full, 1);
        check("t5_ovf", overflow, 1);
        check("t5_head", rd_data, first_word);
        for (int i = 0; i < FIFO_DEPTH; i++) step(0, 0, 0, 1);
        check("t5_empty", empty, 1);
        do_reset();
        for (int i = 0; i < FIFO_DEPTH; i++) step(1, $urandom_range(0, 4095), 0, 0);
        step(1, $urandom_range(0, 4095), 0, 1);
        check("t5_rdwr_full", full, 1);
        check("t5_rdwr_ovf", overflow, 0);
        drain();

        // 6: samples while faulted, then clear and one more
        do_reset();
        thresh_hi = 12'hC00; thresh_lo = 12'h000;
        fill('h800);
        for (int i = 0; i < 20 && !m_fault; i++) step(1, 'hFFF, 0, 0);
        drain();
        for (int i = 0; i < 5; i++) step(1, $urandom_range(0, 4095), 0, 0);
        step(0, 0, 1, 0);
        step(1, $urandom_range(0, 4095), 0, 0);
        drain();
        for (int i = 0; i < 5; i++) step(1, $urandom_range(0, 4095), 0, 0);
        step(0, 0, 0, 0, 1);
        check("t6_rst_empty", empty, 1);
        check("t6_rst_fault", fault, 0);

        // Random soak with shifting thresholds, including lo > hi
        do_reset();
        for (int blk = 0; blk < 12; blk++) begin
            thresh_hi = 12'($urandom_range(0, 4095));
            thresh_lo = 12'($urandom_range(0, 4095));
            mode = $urandom_range(0, 2);
            for (int i = 0; i < 40; i++) begin
                int d;
                case (mode)
                    0: d = $urandom_range(3072, 4095);
                    1: d = $urandom_range(0, 1023);
                    default: d = $urandom_range(0, 4095);
                endcase
                step($urandom_range(0, 1), d, ($urandom_range(0, 15) == 0),
                     ($urandom_range(0, 2) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
